// File: rtl/tmds_shift_scheduler_if.sv
// Word-triple input handshake for tmds_shift_scheduler.
// A transfer happens on a clk_shift edge where in_valid && in_ready; in_ready is the
// consumer's "holding buffer empty" flag and does not depend on in_valid.
interface tmds_shift_scheduler_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_red;
  logic [9:0] in_green;
  logic [9:0] in_blue;

  modport master (
    output in_valid, in_red, in_green, in_blue,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_red, in_green, in_blue,
    output in_ready
  );
endinterface

// File: rtl/tmds_shift_scheduler.sv
// Bit-phase sequencer for the fake-differential TMDS output stage: buffers one word
// triple, loads it on the phase counter and shifts all four channels out LSB first.
module tmds_shift_scheduler #(
  parameter logic       C_ddr        = 1'b0,
  parameter logic [9:0] C_blank      = 10'b1101010100,
  parameter logic [9:0] C_clock_word = 10'b0000011111
) (
  input  logic                         clk_shift,
  input  logic                         reset,
  input  logic                         enable,
  tmds_shift_scheduler_if.slave        in_bus,
  output logic [1:0]                   out_tmds_clock,
  output logic [1:0]                   out_tmds_red,
  output logic [1:0]                   out_tmds_green,
  output logic [1:0]                   out_tmds_blue,
  output logic                         word_strobe,
  output logic                         running,
  output logic [15:0]                  underflow_count,
  output logic [0:0]                   dbg_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [3:0] LAST_PHASE = C_ddr ? 4'd4 : 4'd9;

  logic [0:0] state;
  logic [3:0] phase;
  logic       hold_full;
  logic [9:0] hold_red, hold_green, hold_blue;
  logic [9:0] sr_clock, sr_red, sr_green, sr_blue;
  logic       at_last, do_load, do_stop, accept;

  function automatic logic [9:0] shift_out(input logic [9:0] sr);
    shift_out = C_ddr ? {2'b00, sr[9:2]} : {1'b0, sr[9:1]};
  endfunction

  // SDR drives only lane bit [0]; bit [1] is the later bit in DDR.
  function automatic logic [1:0] lane(input logic [9:0] sr);
    lane = C_ddr ? sr[1:0] : {1'b0, sr[0]};
  endfunction

  always_comb begin
    at_last = (state == RUN) && (phase == LAST_PHASE);
    do_load = enable && ((state == IDLE) || at_last);
    do_stop = !enable && at_last;
    accept  = in_bus.in_valid && !hold_full;
  end

  always_ff @(posedge clk_shift or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      phase           <= 4'd0;
      hold_full       <= 1'b0;
      hold_red        <= 10'd0;
      hold_green      <= 10'd0;
      hold_blue       <= 10'd0;
      sr_clock        <= 10'd0;
      sr_red          <= 10'd0;
      sr_green        <= 10'd0;
      sr_blue         <= 10'd0;
      word_strobe     <= 1'b0;
      underflow_count <= 16'd0;
    end else begin
      word_strobe <= do_load;

      if (do_load) begin
        state    <= RUN;
        phase    <= 4'd0;
        sr_clock <= C_clock_word;
        if (hold_full) begin
          sr_red    <= hold_red;
          sr_green  <= hold_green;
          sr_blue   <= hold_blue;
          hold_full <= 1'b0;
        end else begin
          // A word accepted on this same edge is not yet usable; it waits for the next load.
          sr_red   <= C_blank;
          sr_green <= C_blank;
          sr_blue  <= C_blank;
          if (underflow_count != 16'hFFFF) begin
            underflow_count <= underflow_count + 16'd1;
          end
        end
      end else if (do_stop) begin
        state    <= IDLE;
        phase    <= 4'd0;
        sr_clock <= 10'd0;
        sr_red   <= 10'd0;
        sr_green <= 10'd0;
        sr_blue  <= 10'd0;
      end else if (state == RUN) begin
        phase    <= phase + 4'd1;
        sr_clock <= shift_out(sr_clock);
        sr_red   <= shift_out(sr_red);
        sr_green <= shift_out(sr_green);
        sr_blue  <= shift_out(sr_blue);
      end

      // in_ready low means hold_full, so accept never overlaps a full buffer.
      if (accept) begin
        hold_red   <= in_bus.in_red;
        hold_green <= in_bus.in_green;
        hold_blue  <= in_bus.in_blue;
        hold_full  <= 1'b1;
      end
    end
  end

  assign in_bus.in_ready = ~hold_full;
  assign out_tmds_clock  = lane(sr_clock);
  assign out_tmds_red    = lane(sr_red);
  assign out_tmds_green  = lane(sr_green);
  assign out_tmds_blue   = lane(sr_blue);
  assign running         = (state == RUN);
  assign dbg_state       = state;

endmodule

// File: tb/tb_tmds_shift_scheduler.sv
// Directed bench for tmds_shift_scheduler: an SDR and a DDR instance, a word-level
// scoreboard fed by the stimulus, and point checks on handshake and counters.
module tb_tmds_shift_scheduler;

  localparam logic [9:0] CLKW  = 10'b0000011111;
  localparam logic [9:0] BLANK = 10'b1101010100;

  logic clk_shift = 1'b0;
  logic reset     = 1'b1;
  logic en_s      = 1'b0;
  logic en_d      = 1'b0;
  logic sel       = 1'b0;

  always #5 clk_shift = ~clk_shift;

  tmds_shift_scheduler_if s_if ();
  tmds_shift_scheduler_if d_if ();

  logic [1:0]  s_clk, s_red, s_green, s_blue, d_clk, d_red, d_green, d_blue;
  logic        s_strobe, s_running, d_strobe, d_running;
  logic [15:0] s_uf, d_uf;
  logic [0:0]  s_dbg, d_dbg;

  tmds_shift_scheduler #(.C_ddr(1'b0)) u_sdr (
    .clk_shift(clk_shift), .reset(reset), .enable(en_s), .in_bus(s_if),
    .out_tmds_clock(s_clk), .out_tmds_red(s_red), .out_tmds_green(s_green),
    .out_tmds_blue(s_blue), .word_strobe(s_strobe), .running(s_running),
    .underflow_count(s_uf), .dbg_state(s_dbg)
  );

  tmds_shift_scheduler #(.C_ddr(1'b1)) u_ddr (
    .clk_shift(clk_shift), .reset(reset), .enable(en_d), .in_bus(d_if),
    .out_tmds_clock(d_clk), .out_tmds_red(d_red), .out_tmds_green(d_green),
    .out_tmds_blue(d_blue), .word_strobe(d_strobe), .running(d_running),
    .underflow_count(d_uf), .dbg_state(d_dbg)
  );

  // Monitor follows whichever instance the stimulus is currently exercising.
  logic [1:0] m_clk, m_red, m_green, m_blue;
  logic       m_strobe;
  assign m_clk    = sel ? d_clk    : s_clk;
  assign m_red    = sel ? d_red    : s_red;
  assign m_green  = sel ? d_green  : s_green;
  assign m_blue   = sel ? d_blue   : s_blue;
  assign m_strobe = sel ? d_strobe : s_strobe;

  logic [39:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Word-level scoreboard: rebuild {clock,red,green,blue} over one word period.
  int          cap_cnt   = 0;
  logic        capturing = 1'b0;
  logic [39:0] cap_word  = '0;

  always @(negedge clk_shift) begin : monitor
    int nb;
    int idx;
    nb = sel ? 2 : 1;
    if (reset) begin
      capturing = 1'b0;
    end else begin
      if (m_strobe) begin
        chk("strobe_period", 40'(capturing), 40'd0);
        capturing = 1'b1;
        cap_cnt   = 0;
        cap_word  = '0;
      end
      if (capturing) begin
        idx = cap_cnt * nb;
        cap_word[30 + idx] = m_clk[0];
        cap_word[20 + idx] = m_red[0];
        cap_word[10 + idx] = m_green[0];
        cap_word[idx]      = m_blue[0];
        if (nb == 2) begin
          cap_word[31 + idx] = m_clk[1];
          cap_word[21 + idx] = m_red[1];
          cap_word[11 + idx] = m_green[1];
          cap_word[1 + idx]  = m_blue[1];
        end
        cap_cnt++;
        if (cap_cnt * nb == 10) begin
          capturing = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%h expected=none", cap_word);
          end else begin
            chk("word", cap_word, exp_q.pop_front());
          end
        end
      end
      if (!sel) chk("sdr_bit1", 40'({m_clk[1], m_red[1], m_green[1], m_blue[1]}), 40'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_shift);
    #1;
  endtask

  task automatic offer(input logic which, input logic [9:0] r, input logic [9:0] g,
                       input logic [9:0] b);
    if (which) begin
      d_if.in_valid = 1'b1; d_if.in_red = r; d_if.in_green = g; d_if.in_blue = b;
    end else begin
      s_if.in_valid = 1'b1; s_if.in_red = r; s_if.in_green = g; s_if.in_blue = b;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    s_if.in_valid = 1'b0; s_if.in_red = '0; s_if.in_green = '0; s_if.in_blue = '0;
    d_if.in_valid = 1'b0; d_if.in_red = '0; d_if.in_green = '0; d_if.in_blue = '0;
    reset = 1'b1;
    tick(2);
    chk("rst_ready", 40'(s_if.in_ready), 40'd1);
    chk("rst_uf", 40'(s_uf), 40'd0);
    chk("rst_lanes", 40'({s_clk, s_red, s_green, s_blue}), 40'd0);
    chk("rst_running", 40'(s_running), 40'd0);
    chk("rst_strobe", 40'(s_strobe), 40'd0);
    reset = 1'b0;
    tick(1);

    // SDR: prefill while idle, then enable
    offer(1'b0, 10'h2AB, 10'h155, 10'h3FF);
    tick(1);
    s_if.in_valid = 1'b0;
    chk("prefill_ready", 40'(s_if.in_ready), 40'd0);
    chk("idle_lanes", 40'({s_clk, s_red, s_green, s_blue}), 40'd0);
    exp_q.push_back({CLKW, 10'h2AB, 10'h155, 10'h3FF});
    en_s = 1'b1;
    tick(1);
    chk("l0_strobe", 40'(s_strobe), 40'd1);
    chk("l0_ready", 40'(s_if.in_ready), 40'd1);
    chk("l0_running", 40'(s_running), 40'd1);
    chk("l0_red_lane", 40'(s_red), 40'd1);
    chk("l0_clk_lane", 40'(s_clk), 40'd1);
    chk("l0_uf", 40'(s_uf), 40'd0);

    // SDR: no data offered, two blank words
    exp_q.push_back({CLKW, BLANK, BLANK, BLANK});
    exp_q.push_back({CLKW, BLANK, BLANK, BLANK});
    tick(1);
    chk("l0p1_strobe", 40'(s_strobe), 40'd0);
    tick(9);
    chk("uf_1", 40'(s_uf), 40'd1);
    chk("l1_strobe", 40'(s_strobe), 40'd1);
    tick(10);
    chk("uf_2", 40'(s_uf), 40'd2);
    chk("uf_ready", 40'(s_if.in_ready), 40'd1);

    // SDR: word offered exactly on a load edge with the buffer empty
    tick(9);
    offer(1'b0, 10'h0F0, 10'h30C, 10'h001);
    exp_q.push_back({CLKW, BLANK, BLANK, BLANK});
    exp_q.push_back({CLKW, 10'h0F0, 10'h30C, 10'h001});
    tick(1);
    s_if.in_valid = 1'b0;
    chk("race_ready", 40'(s_if.in_ready), 40'd0);
    chk("race_uf", 40'(s_uf), 40'd3);
    chk("race_strobe", 40'(s_strobe), 40'd1);
    tick(5);
    chk("race_ready_mid", 40'(s_if.in_ready), 40'd0);
    tick(4);
    tick(1);
    chk("race_load_ready", 40'(s_if.in_ready), 40'd1);
    chk("race_load_uf", 40'(s_uf), 40'd3);
    chk("race_load_strobe", 40'(s_strobe), 40'd1);

    // SDR: drop enable at phase 3, word must complete
    tick(3);
    en_s = 1'b0;
    tick(6);
    chk("stop_running_ph9", 40'(s_running), 40'd1);
    tick(1);
    chk("stop_running", 40'(s_running), 40'd0);
    chk("stop_lanes", 40'({s_clk, s_red, s_green, s_blue}), 40'd0);
    chk("stop_strobe", 40'(s_strobe), 40'd0);
    chk("stop_uf", 40'(s_uf), 40'd3);
    tick(2);
    chk("idle_strobe", 40'(s_strobe), 40'd0);

    // SDR: reset at phase 4 with a word held
    offer(1'b0, 10'h3E0, 10'h01F, 10'h2D2);
    tick(1);
    s_if.in_valid = 1'b0;
    en_s = 1'b1;
    tick(1);
    offer(1'b0, 10'h123, 10'h234, 10'h345);
    tick(1);
    s_if.in_valid = 1'b0;
    chk("held_ready", 40'(s_if.in_ready), 40'd0);
    tick(3);
    #2 reset = 1'b1;
    #1;
    chk("arst_lanes", 40'({s_clk, s_red, s_green, s_blue}), 40'd0);
    chk("arst_uf", 40'(s_uf), 40'd0);
    chk("arst_ready", 40'(s_if.in_ready), 40'd1);
    chk("arst_running", 40'(s_running), 40'd0);
    chk("arst_strobe", 40'(s_strobe), 40'd0);
    exp_q.push_back({CLKW, BLANK, BLANK, BLANK});
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("post_rst_strobe", 40'(s_strobe), 40'd1);
    chk("post_rst_uf", 40'(s_uf), 40'd1);
    en_s = 1'b0;
    tick(10);
    chk("post_rst_stop", 40'(s_running), 40'd0);

    // DDR: same first word, 5-clock word period
    sel = 1'b1;
    offer(1'b1, 10'h2AB, 10'h155, 10'h3FF);
    tick(1);
    d_if.in_valid = 1'b0;
    exp_q.push_back({CLKW, 10'h2AB, 10'h155, 10'h3FF});
    exp_q.push_back({CLKW, BLANK, BLANK, BLANK});
    en_d = 1'b1;
    tick(1);
    chk("ddr_l0_strobe", 40'(d_strobe), 40'd1);
    chk("ddr_l0_red", 40'(d_red), 40'd3);
    chk("ddr_l0_clk", 40'(d_clk), 40'd3);
    chk("ddr_l0_uf", 40'(d_uf), 40'd0);
    tick(1);
    chk("ddr_p1_strobe", 40'(d_strobe), 40'd0);
    chk("ddr_p1_red", 40'(d_red), 40'd2);
    tick(3);
    chk("ddr_p4_strobe", 40'(d_strobe), 40'd0);
    tick(1);
    chk("ddr_l1_strobe", 40'(d_strobe), 40'd1);
    chk("ddr_l1_uf", 40'(d_uf), 40'd1);
    en_d = 1'b0;
    tick(5);
    chk("ddr_stop_running", 40'(d_running), 40'd0);
    chk("ddr_stop_lanes", 40'({d_clk, d_red, d_green, d_blue}), 40'd0);
    chk("ddr_stop_uf", 40'(d_uf), 40'd1);

    tick(2);
    chk("queue_empty", 40'(exp_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_shift_scheduler.md
Name: tmds_shift_scheduler

Overview:
- Clk_shift-domain sequencer that feeds the fake-differential output stage.
- Accepts 10-bit TMDS words for red, green and blue through a valid/ready handshake into a one-deep holding buffer.
- Schedules word loads on the bit-phase counter and shifts the words out LSB first as 2-bit lanes for SDR (1 bit/clock) or DDR (2 bits/clock); bit [1] of each lane is the later bit.
- Generates the TMDS clock-channel pattern, substitutes a blanking control symbol on underflow, and reports underflow statistics.

Parameters:
- C_ddr, 1'b0, 0: SDR, 1 bit per clk_shift, 10 phases per word; 1: DDR, 2 bits per clk_shift, 5 phases per word.
- C_blank, 10'b1101010100, TMDS control symbol (C1C0=00) inserted on underflow and in drain/idle-to-run loads with an empty buffer.
- C_clock_word, 10'b0000011111, clock-channel word, shifted LSB first.

Ports:
- clk_shift  in  1  bit clock; the only clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  1: run/continue; 0: finish the current word, then idle.
- in_valid  in  1  word triple valid.
- in_ready  out  1  holding buffer empty; a transfer occurs when in_valid && in_ready.
- in_red, in_green, in_blue  in  10 each  TMDS words.
- out_tmds_clock, out_tmds_red, out_tmds_green, out_tmds_blue  out  2 each  lane bits to the fake-differential stage.
- word_strobe  out  1  one-cycle pulse on every word load.
- running  out  1  state == RUN.
- underflow_count  out  16  saturating count of blank substitutions in RUN.

Behaviour:
- Definitions: B = C_ddr ? 2 : 1; N = 10/B; phase counter 0..N-1.
- Reset (asynchronous) values:
  - state = IDLE; phase = 0; hold_full = 0.
  - All shift registers = 0; all out_tmds_* = 0.
  - word_strobe = 0; underflow_count = 0.
  - in_ready = 1 (reflects hold_full = 0).
- States:
  - IDLE: outputs held at 0, phase held at 0. The buffer may prefill: in_ready = ~hold_full.
  - IDLE with enable = 1 at edge t: at t+1, state = RUN, phase = 0, load performed, word_strobe = 1.
  - RUN: each edge shifts all four shift registers right by B and increments phase. At phase N-1 the edge performs a load instead of a shift, and phase wraps to 0.
  - RUN with enable = 0 at a load edge: state goes to IDLE; shift registers and outputs go to 0; no load. Lowering enable mid-word never truncates the word.
- Load: one shared operation on the clock and data channels.
  - Clock shift register <= C_clock_word.
  - If hold_full: data shift registers <= hold contents, hold_full <= 0.
  - Else: all three data shift registers <= C_blank, and underflow_count increments, saturating at 16'hFFFF. A load from IDLE with an empty buffer also counts.
- Outputs: out_tmds_x = the low B bits of shift register x. In SDR, bit [1] = 0.
- Output latency: the first bit of a loaded word appears on the edge of the load itself (registered shift register, no extra stage).
- Handshake:
  - in_ready = ~hold_full, purely from the register.
  - Accept sets hold_full = 1 and captures all three words.
  - Accept and load on the same edge with hold_full = 0: the load uses C_blank (counted as underflow), and the accepted word stays in hold for the next load.
  - Accept while hold_full cannot occur.
  - in_valid without in_ready: nothing is captured; the source holds its data.
- Sustained throughput: one word per N clocks. in_ready drops on the accept edge and rises on the load edge.
- Mid-operation reset: immediate return to reset values; the held word is discarded.

Test Plan:
- SDR, prefill red = 10'h2AB, green = 10'h155, blue = 10'h3FF, then enable:
  - word_strobe at t+1.
  - out_tmds_red[0] sequence over 10 clocks: 1,1,0,1,0,1,0,1,0,1.
  - out_tmds_clock[0]: 1,1,1,1,1,0,0,0,0,0.
  - Bit [1] of every lane stays 0.
- DDR, same words:
  - 5-clock word period.
  - out_tmds_red sequence: 2'b11, 2'b10, 2'b10, 2'b10, 2'b10.
  - word_strobe every 5 clocks.
- Enable with no data offered:
  - Each load emits 1101010100 on red, green and blue.
  - underflow_count increments by 1 per word period.
  - in_ready stays 1.
- Offer a word exactly on a load edge with the buffer empty:
  - That load is blank; underflow_count +1.
  - The next load outputs the offered word.
  - in_ready = 0 in between.
- Deassert enable at phase 3 (SDR):
  - The word completes through phase 9.
  - The next edge gives running = 0 and outputs 0.
  - No word_strobe.
- Assert reset at phase 4 with hold_full = 1:
  - All outputs 0 asynchronously.
  - underflow_count = 0; in_ready = 1.
  - After release, the first load with an empty buffer is blank.
